// File: rtl/dbg_trigger_unit_pkg.sv
// Shared definitions for the b16 debug/trigger unit.
//   dbg_off_e    : local register offsets (haddr[4:1]) inside the debug window
//   CFG_*        : comparator type-enable bit positions in CMPCFG
//   CTRL_*       : CTRL write bit positions
//   STATUS_*     : STATUS bit positions for step hit and halted
//   sel_width()  : width of the SEL register for a given comparator count
package dbg_trigger_unit_pkg;

  typedef enum logic [3:0] {
    OFF_CTRL    = 4'd8,
    OFF_STEPCNT = 4'd9,
    OFF_STATUS  = 4'd10,
    OFF_SEL     = 4'd11,
    OFF_CMPADDR = 4'd12,
    OFF_CMPMASK = 4'd13,
    OFF_CMPCFG  = 4'd14,
    OFF_RSVD    = 4'd15
  } dbg_off_e;

  localparam int unsigned CFG_FETCH   = 0;
  localparam int unsigned CFG_READ    = 1;
  localparam int unsigned CFG_WRITE   = 2;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_SKIP   = 1;

  localparam int unsigned STATUS_STEP = 8;
  localparam int unsigned STATUS_HALT = 15;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_trigger_unit_if.sv
// Host/debug bus of the trigger unit.
//   haddr/hdata/hr/hw : host address, write data, read strobe, byte write strobes
//   hrdata            : local register read data
//   dr/dw/daddr       : forwarded cpu debug port strobes and register index
// master = host side, slave = trigger unit side.
interface dbg_trigger_unit_if #(
  parameter int unsigned L = 16
);
  logic [L-1:0] haddr;
  logic [L-1:0] hdata;
  logic         hr;
  logic [1:0]   hw;
  logic [L-1:0] hrdata;
  logic         dr;
  logic         dw;
  logic [2:0]   daddr;

  modport master (
    output haddr, hdata, hr, hw,
    input  hrdata, dr, dw, daddr
  );

  modport slave (
    input  haddr, hdata, hr, hw,
    output hrdata, dr, dw, daddr
  );
endinterface

// File: rtl/dbg_trigger_unit_comparator.sv
// One address comparator channel: CMPADDR/CMPMASK/CMPCFG registers and the
// qualified match.
//   clk, nreset            : clock, async active-low reset
//   wdata, we_addr/mask/cfg: register write data and per-register write enables
//   cpu_addr/fetch/rd/wr   : observed cpu bus cycle
//   counted                : drun & run_in, matches only count while set
//   skip                   : suppress fetch-type matches
//   addr, mask, cfg        : register contents for readback
//   hit                    : qualified match this cycle
module dbg_comparator
  import dbg_trigger_unit_pkg::*;
#(
  parameter int unsigned L = 16
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [L-1:0] wdata,
  input  logic         we_addr,
  input  logic         we_mask,
  input  logic         we_cfg,
  input  logic [L-1:0] cpu_addr,
  input  logic         cpu_fetch,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic         counted,
  input  logic         skip,
  output logic [L-1:0] addr,
  output logic [L-1:0] mask,
  output logic [2:0]   cfg,
  output logic         hit
);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr <= '1;
      mask <= '0;
      cfg  <= '0;
    end else begin
      if (we_addr) addr <= wdata;
      if (we_mask) mask <= wdata;
      if (we_cfg)  cfg  <= wdata[2:0];
    end
  end

  logic addr_eq;
  logic type_ok;

  always_comb begin
    addr_eq = ((cpu_addr ^ addr) & ~mask) == '0;
    // A fetch is never also treated as a data read.
    type_ok = (cfg[CFG_FETCH] & cpu_fetch & ~skip)
            | (cfg[CFG_READ]  & cpu_rd & ~cpu_fetch)
            | (cfg[CFG_WRITE] & (|cpu_wr));
    hit     = counted & addr_eq & type_ok;
  end

endmodule

// File: rtl/dbg_trigger_unit.sv
// b16 debug/trigger unit: NCMP address comparators, single-step counter,
// sticky hit status and halt/resume control of the cpu run enable.
//   clk, nreset : clock, async active-low reset
//   bus         : host/debug bus (slave); offsets 0-7 of the window are
//                 forwarded to the cpu debug port, 8-15 are local registers
//   cpu_addr, cpu_fetch, cpu_rd, cpu_wr : observed cpu bus cycle
//   run_in      : cpu qualifier, matches count only when drun & run_in
//   drun        : cpu run enable
//   halted      : ~drun
module dbg_trigger_unit
  import dbg_trigger_unit_pkg::*;
#(
  parameter int unsigned    L       = 16,
  parameter int unsigned    NCMP    = 4,
  parameter logic [L-6:0]   DBGADDR = 11'h7FF
) (
  input  logic                clk,
  input  logic                nreset,
  dbg_trigger_unit_if.slave   bus,
  input  logic [L-1:0]        cpu_addr,
  input  logic                cpu_fetch,
  input  logic                cpu_rd,
  input  logic [1:0]          cpu_wr,
  input  logic                run_in,
  output logic                drun,
  output logic                halted
);

  localparam int unsigned SELW = sel_width(NCMP);

  logic [3:0]        off;
  logic              dsel;
  logic              wr_any;
  logic              loc;
  logic              unused_haddr0;

  logic              we_ctrl, we_step, we_status, we_sel;
  logic [NCMP-1:0]   we_addr, we_mask, we_cfg;
  logic              go;

  logic [L-1:0]      stepcnt;
  logic [SELW-1:0]   sel;
  logic              skip;
  logic [STATUS_STEP:0] sts, sts_set, sts_clr;

  logic              counted;
  logic              count_fetch;
  logic              step_hit;
  logic              any_hit;
  logic [NCMP-1:0]   cmp_hit;
  logic [L-1:0]      cmp_addr [NCMP];
  logic [L-1:0]      cmp_mask [NCMP];
  logic [2:0]        cmp_cfg  [NCMP];
  logic [L-1:0]      rdata;

  // Window decode and cpu debug port forwarding
  always_comb begin
    off           = bus.haddr[4:1];
    dsel          = bus.haddr[L-1:5] == DBGADDR;
    wr_any        = |bus.hw;
    loc           = dsel & off[3];
    unused_haddr0 = bus.haddr[0];
    bus.dr        = dsel & ~off[3] & bus.hr;
    bus.dw        = dsel & ~off[3] & wr_any;
    bus.daddr     = bus.haddr[3:1];
  end

  // Local register write decode
  always_comb begin
    we_ctrl   = 1'b0;
    we_step   = 1'b0;
    we_status = 1'b0;
    we_sel    = 1'b0;
    we_addr   = '0;
    we_mask   = '0;
    we_cfg    = '0;
    if (loc && wr_any) begin
      case (dbg_off_e'(off))
        OFF_CTRL:    we_ctrl      = 1'b1;
        OFF_STEPCNT: we_step      = 1'b1;
        OFF_STATUS:  we_status    = 1'b1;
        OFF_SEL:     we_sel       = 1'b1;
        OFF_CMPADDR: we_addr[sel] = 1'b1;
        OFF_CMPMASK: we_mask[sel] = 1'b1;
        OFF_CMPCFG:  we_cfg[sel]  = 1'b1;
        default:     ;
      endcase
    end
  end

  always_comb begin
    go          = we_ctrl & bus.hdata[CTRL_GO];
    counted     = drun & run_in;
    count_fetch = counted & cpu_fetch;
    // A STEPCNT write on the same edge replaces the decrement, so no step hit.
    step_hit    = count_fetch & (stepcnt == L'(1)) & ~we_step;
    any_hit     = (|cmp_hit) | step_hit;
    halted      = ~drun;

    sts_set              = '0;
    sts_set[NCMP-1:0]    = cmp_hit;
    sts_set[STATUS_STEP] = step_hit;
    sts_clr              = we_status ? bus.hdata[STATUS_STEP:0] : '0;
  end

  for (genvar g = 0; g < NCMP; g++) begin : g_cmp
    dbg_comparator #(
      .L (L)
    ) u_cmp (
      .clk       (clk),
      .nreset    (nreset),
      .wdata     (bus.hdata),
      .we_addr   (we_addr[g]),
      .we_mask   (we_mask[g]),
      .we_cfg    (we_cfg[g]),
      .cpu_addr  (cpu_addr),
      .cpu_fetch (cpu_fetch),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .counted   (counted),
      .skip      (skip),
      .addr      (cmp_addr[g]),
      .mask      (cmp_mask[g]),
      .cfg       (cmp_cfg[g]),
      .hit       (cmp_hit[g])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      drun    <= 1'b1;
      skip    <= 1'b0;
      stepcnt <= '0;
      sel     <= '0;
      sts     <= '0;
    end else begin
      // go beats a same-edge hit; the hit still records its status bit.
      if (go)           drun <= 1'b1;
      else if (any_hit) drun <= 1'b0;

      if (go)               skip <= bus.hdata[CTRL_SKIP];
      else if (count_fetch) skip <= 1'b0;

      if (we_step)                          stepcnt <= bus.hdata;
      else if (count_fetch && stepcnt != '0) stepcnt <= stepcnt - 1'b1;

      if (we_sel) sel <= SELW'(bus.hdata % L'(NCMP));

      // Set has priority over write-1-to-clear.
      sts <= (sts & ~sts_clr) | sts_set;
    end
  end

  // Local register readback, combinational from the offset
  always_comb begin
    rdata = '0;
    case (dbg_off_e'(off))
      OFF_CTRL:    rdata[L-1] = drun;
      OFF_STEPCNT: rdata = stepcnt;
      OFF_STATUS: begin
        rdata[STATUS_STEP:0] = sts;
        rdata[STATUS_HALT]   = ~drun;
      end
      OFF_SEL:     rdata[SELW-1:0] = sel;
      OFF_CMPADDR: rdata = cmp_addr[sel];
      OFF_CMPMASK: rdata = cmp_mask[sel];
      OFF_CMPCFG:  rdata[2:0] = cmp_cfg[sel];
      default:     ;
    endcase
    bus.hrdata = (loc && bus.hr) ? rdata : '0;
  end

endmodule

// File: tb/tb_dbg_trigger_unit.sv
module tb_dbg_trigger_unit;

  typedef enum int {K_HRDATA, K_DRUN, K_HALTED, K_DBG} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   mon_cnt = 0;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b1;
  logic        probe  = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_fetch;
  logic        cpu_rd;
  logic [1:0]  cpu_wr;
  logic        run_in;
  logic        drun;
  logic        halted;

  dbg_trigger_unit_if #(.L(16)) bus();

  dbg_trigger_unit #(
    .L       (16),
    .NCMP    (4),
    .DBGADDR (11'h7FF)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus),
    .cpu_addr  (cpu_addr),
    .cpu_fetch (cpu_fetch),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .run_in    (run_in),
    .drun      (drun),
    .halted    (halted)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Monitor: pops expected entries when a check is flagged for this cycle
  initial begin
    forever begin
      @(negedge clk or posedge probe);
      for (int i = 0; i < mon_cnt; i++) begin
        exp_t        e;
        logic [15:0] act;
        if (sbq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
          break;
        end
        e = sbq.pop_front();
        case (e.kind)
          K_HRDATA: act = bus.hrdata;
          K_DRUN:   act = {15'b0, drun};
          K_HALTED: act = {15'b0, halted};
          default:  act = {11'b0, bus.dr, bus.dw, bus.daddr};
        endcase
        n_vec++;
        if (act !== e.exp) begin
          n_miss++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    bus.haddr = 16'h0000;
    bus.hdata = 16'h0000;
    bus.hr    = 1'b0;
    bus.hw    = 2'b00;
    cpu_addr  = 16'h0000;
    cpu_fetch = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 2'b00;
    run_in    = 1'b1;
    mon_cnt   = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_v(input kind_e k, input logic [15:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sbq.push_back(e);
    mon_cnt++;
  endtask

  task automatic set_wr(input int off, input logic [15:0] d);
    bus.haddr = 16'hFFE0 | 16'(off << 1);
    bus.hdata = d;
    bus.hw    = 2'b11;
  endtask

  task automatic rdc(input int off, input logic [15:0] v, input string n);
    bus.haddr = 16'hFFE0 | 16'(off << 1);
    bus.hr    = 1'b1;
    expect_v(K_HRDATA, v, n);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    set_wr(off, d);
    cyc();
  endtask

  task automatic rd1(input int off, input logic [15:0] v, input string n);
    rdc(off, v, n);
    cyc();
  endtask

  task automatic set_fetch(input logic [15:0] a);
    cpu_addr  = a;
    cpu_fetch = 1'b1;
  endtask

  task automatic fire();
    probe = 1'b1;
    #1;
    probe   = 1'b0;
    mon_cnt = 0;
  endtask

  initial begin
    idle();
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b1;

    // Reset state and cpu port forwarding
    expect_v(K_DRUN, 16'h0001, "rst_drun");
    expect_v(K_HALTED, 16'h0000, "rst_halted");
    cyc();
    rd1(10, 16'h0000, "rst_status");
    rd1(8,  16'h8000, "rst_ctrl");
    rd1(12, 16'hFFFF, "rst_cmpaddr0");
    rd1(13, 16'h0000, "rst_cmpmask0");
    rd1(14, 16'h0000, "rst_cmpcfg0");
    rd1(9,  16'h0000, "rst_stepcnt");
    rd1(11, 16'h0000, "rst_sel");
    rd1(15, 16'h0000, "rsvd_read");
    bus.haddr = 16'hFFE6; bus.hr = 1'b1;
    expect_v(K_DBG, 16'h0013, "cpu_off3_rd");
    expect_v(K_HRDATA, 16'h0000, "cpu_off3_rdata");
    cyc();
    bus.haddr = 16'hFFEA; bus.hdata = 16'hABCD; bus.hw = 2'b10;
    expect_v(K_DBG, 16'h000D, "cpu_off5_wr");
    cyc();
    bus.haddr = 16'h7FF0; bus.hr = 1'b1;
    expect_v(K_DBG, 16'h0000, "nowin_dbg");
    expect_v(K_HRDATA, 16'h0000, "nowin_rdata");
    cyc();

    // Fetch breakpoint and skip_first resume
    wr(12, 16'h1234);
    wr(14, 16'h0001);
    rd1(12, 16'h1234, "cmp0_addr_rb");
    rd1(14, 16'h0001, "cmp0_cfg_rb");
    set_fetch(16'h1234);
    expect_v(K_DRUN, 16'h0001, "bp_before_edge");
    cyc();
    expect_v(K_DRUN, 16'h0000, "bp_halt");
    rdc(10, 16'h8001, "bp_status");
    cyc();
    wr(8, 16'h0003);
    set_fetch(16'h1234);
    expect_v(K_DRUN, 16'h0001, "skip_resumed");
    cyc();
    expect_v(K_DRUN, 16'h0001, "skip_no_halt");
    cyc();
    wr(10, 16'h0001);
    rd1(10, 16'h0000, "w1c_clear");
    set_fetch(16'h1234);
    cyc();
    expect_v(K_DRUN, 16'h0000, "rehit_halt");
    rdc(10, 16'h8001, "rehit_status");
    cyc();

    // Masked write watchpoint on channel 1 (SEL=5 wraps to 1)
    wr(10, 16'h01FF);
    wr(11, 16'h0005);
    rd1(11, 16'h0001, "sel_wrap");
    wr(12, 16'h2000);
    wr(13, 16'h00FF);
    wr(14, 16'h0004);
    rd1(13, 16'h00FF, "cmp1_mask_rb");
    wr(8, 16'h0001);
    cpu_addr = 16'h20A7; cpu_rd = 1'b1;
    cyc();
    expect_v(K_DRUN, 16'h0001, "wp_rd_nohit");
    cyc();
    cpu_addr = 16'h2100; cpu_wr = 2'b01;
    cyc();
    expect_v(K_DRUN, 16'h0001, "wp_wr_outside");
    cyc();
    cpu_addr = 16'h20A7; cpu_wr = 2'b01;
    cyc();
    expect_v(K_DRUN, 16'h0000, "wp_wr_halt");
    rdc(10, 16'h8002, "wp_status");
    cyc();

    // Single step with an uncounted fetch in between
    wr(10, 16'h01FF);
    wr(9, 16'h0003);
    wr(8, 16'h0001);
    set_fetch(16'h0100);
    cyc();
    set_fetch(16'h0102); run_in = 1'b0;
    rdc(9, 16'h0002, "step_after1");
    cyc();
    set_fetch(16'h0104);
    rdc(9, 16'h0002, "step_runin0");
    cyc();
    expect_v(K_DRUN, 16'h0001, "step_running");
    rdc(9, 16'h0001, "step_after2");
    cyc();
    set_fetch(16'h0106);
    cyc();
    expect_v(K_DRUN, 16'h0000, "step_halt");
    rdc(10, 16'h8100, "step_status");
    cyc();
    rd1(9, 16'h0000, "step_zero");

    // Same-edge interactions
    wr(10, 16'h01FF);
    wr(8, 16'h0001);
    set_wr(8, 16'h0001); set_fetch(16'h1234);
    cyc();
    expect_v(K_DRUN, 16'h0001, "go_vs_hit_drun");
    rdc(10, 16'h0001, "go_vs_hit_status");
    cyc();
    set_wr(10, 16'h0001); set_fetch(16'h1234);
    cyc();
    expect_v(K_DRUN, 16'h0000, "w1c_vs_hit_drun");
    rdc(10, 16'h8001, "w1c_vs_hit_status");
    cyc();
    wr(10, 16'h01FF);
    wr(9, 16'h0001);
    wr(8, 16'h0001);
    set_wr(9, 16'h0005); set_fetch(16'h0200);
    cyc();
    expect_v(K_DRUN, 16'h0001, "stepwr_vs_dec_drun");
    rdc(9, 16'h0005, "stepwr_vs_dec_cnt");
    cyc();
    rd1(10, 16'h0000, "stepwr_no_hit");
    set_fetch(16'h1234);
    cyc();
    expect_v(K_DRUN, 16'h0000, "hit_fetch_halt");
    rdc(9, 16'h0004, "hit_fetch_counted");
    cyc();
    set_fetch(16'h0300);
    cyc();
    rd1(9, 16'h0004, "halted_frozen");
    wr(9, 16'h0005);

    // Asynchronous reset with the clock stopped
    clk_en = 1'b0;
    #3;
    nreset = 1'b0;
    #1;
    expect_v(K_DRUN, 16'h0001, "async_drun");
    expect_v(K_HALTED, 16'h0000, "async_halted");
    rdc(9, 16'h0000, "async_stepcnt");
    fire();
    #2;
    rdc(14, 16'h0000, "async_cfg0");
    fire();
    #2;
    rdc(12, 16'hFFFF, "async_addr0");
    fire();
    #2;
    nreset = 1'b1;
    idle();
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    wr(11, 16'h0001);
    rd1(14, 16'h0000, "rst_cfg1");
    rd1(12, 16'hFFFF, "rst_addr1");
    rd1(10, 16'h0000, "rst_status_after");

    cyc();
    cyc();
    if (sbq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
